video_axis_bridge: RTL and testbench

Parametrised successor to the HDMI pipeline's raster-to-AXI4-Stream conversion. It takes raster timing and pixel data from the video generator and buffers pixels in an internal FIFO so downstream `tready` backpressure is honoured rather than ignored. It widens colour depth at a configurable ratio and adds frame-level resynchronisation, overflow detection and frame/drop counters. It sits between `video_gen` and the AXI4S-to-Video-Out core.

---
 rtl/video_axis_bridge.sv | 144 ++++++++++++++
 tb/tb_video_axis_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_axis_bridge.sv
// Raster-to-AXI4-Stream bridge: captures active pixels, widens colour depth and
// buffers them in a FWFT FIFO with SOF resynchronisation after overflow.
module video_axis_bridge #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COORD_W    = 10,
  parameter int IN_BPC     = 4,
  parameter int OUT_BPC    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            video_on,
  input  logic [COORD_W-1:0]              pixel_x,
  input  logic [COORD_W-1:0]              pixel_y,
  input  logic [3*IN_BPC-1:0]             rgb_in,
  output logic [3*OUT_BPC-1:0]            tdata,
  output logic                            tvalid,
  output logic                            tuser,
  output logic                            tlast,
  input  logic                            tready,
  input  logic                            clear_status,
  output logic                            overflow,
  output logic [15:0]                     frame_count,
  output logic [15:0]                     drop_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = 3 * OUT_BPC;
  localparam int EW = DW + 2;

  typedef enum logic [1:0] {WAIT_SOF, STREAM, RESYNC} state_t;

  state_t               state_reg, state_next;
  logic                 cap_valid_reg;
  logic [3*IN_BPC-1:0]  cap_rgb_reg;
  logic                 cap_sof_reg;
  logic                 cap_eol_reg;
  logic [DW-1:0]        wide_rgb;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [EW-1:0]        head;
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]        level_reg;
  logic                 overflow_reg;
  logic [15:0]          frame_count_reg, drop_count_reg;
  logic                 push_req, push, pop, full, discard, drop_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_valid_reg <= 1'b0;
      cap_rgb_reg   <= '0;
      cap_sof_reg   <= 1'b0;
      cap_eol_reg   <= 1'b0;
    end else begin
      cap_valid_reg <= video_on;
      cap_rgb_reg   <= rgb_in;
      cap_sof_reg   <= (pixel_x == '0) && (pixel_y == '0);
      cap_eol_reg   <= (pixel_x == COORD_W'(H_RES - 1));
    end
  end

  // Each output bit, counted from the channel MSB, repeats input bit (j mod IN_BPC).
  genvar gi, gb;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      for (gb = 0; gb < OUT_BPC; gb++) begin : g_bit
        assign wide_rgb[gi*OUT_BPC + gb] =
          cap_rgb_reg[gi*IN_BPC + IN_BPC - 1 - ((OUT_BPC - 1 - gb) % IN_BPC)];
      end
    end
  endgenerate

  assign full      = (level_reg == LW'(FIFO_DEPTH));
  assign tvalid    = (level_reg != '0);
  assign pop       = tvalid && tready;
  assign push_req  = cap_valid_reg && ((state_reg == STREAM) || cap_sof_reg);
  assign discard   = cap_valid_reg && !push_req;
  assign push      = push_req && (!full || pop);
  assign drop_full = push_req && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= WAIT_SOF;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_SOF, RESYNC: if (push)      state_next = STREAM;
      STREAM:           if (drop_full) state_next = RESYNC;
      default:                         state_next = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {cap_sof_reg, cap_eol_reg, wide_rgb};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Outputs are forced to zero when empty so reset clears them without a clock edge.
  assign head  = mem[rd_ptr_reg];
  assign tdata = tvalid ? head[DW-1:0] : '0;
  assign tlast = tvalid && head[DW];
  assign tuser = tvalid && head[DW+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg    <= 1'b0;
      frame_count_reg <= '0;
      drop_count_reg  <= '0;
    end else begin
      if (clear_status)   overflow_reg <= 1'b0;
      else if (drop_full) overflow_reg <= 1'b1;
      if (push && cap_sof_reg) frame_count_reg <= frame_count_reg + 16'd1;
      if (clear_status)
        drop_count_reg <= '0;
      else if ((discard || drop_full) && (drop_count_reg != 16'hFFFF))
        drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign overflow    = overflow_reg;
  assign frame_count = frame_count_reg;
  assign drop_count  = drop_count_reg;
  assign fifo_level  = level_reg;

endmodule

// File: tb/tb_video_axis_bridge.sv
// Bench for video_axis_bridge: small raster, queue scoreboard checked every cycle
// plus directed checks for alignment, backpressure, overflow/resync and reset.
module tb_video_axis_bridge;

  localparam int H = 16;
  localparam int V = 4;
  localparam int HT = 20;
  localparam int VT = 6;
  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] rgb_in;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast, tready, clear_status, overflow;
  logic [15:0] frame_count, drop_count;
  logic [4:0]  fifo_level;

  video_axis_bridge #(
    .H_RES(H), .V_RES(V), .COORD_W(10), .IN_BPC(4), .OUT_BPC(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .rgb_in(rgb_in), .tdata(tdata), .tvalid(tvalid), .tuser(tuser), .tlast(tlast),
    .tready(tready), .clear_status(clear_status), .overflow(overflow),
    .frame_count(frame_count), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hx = 0, vy = 0;
  int bc = 0, uc = 0, lc = 0;
  int probe = -1;
  logic probe_arm = 1'b0;
  logic reset_drv, tready_drv, clear_drv;

  // Reference model state
  logic [25:0] m_q[$];
  logic        m_stream, m_ovf;
  logic [15:0] m_frames, m_drops;
  logic        cap_v, cap_sof, cap_eol;
  logic [11:0] cap_rgb;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] widen(input logic [11:0] c);
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_stream = 1'b0; m_ovf = 1'b0; m_frames = '0; m_drops = '0;
    cap_v = 1'b0; cap_sof = 1'b0; cap_eol = 1'b0; cap_rgb = '0;
  endtask

  task automatic model_edge();
    logic pop, want, disc, full, dropf;
    pop   = (m_q.size() != 0) && tready;
    want  = cap_v && (m_stream || cap_sof);
    disc  = cap_v && !want;
    full  = (m_q.size() == DEPTH);
    dropf = want && full && !pop;
    if (pop) void'(m_q.pop_front());
    if (want && !dropf) begin
      m_q.push_back({cap_sof, cap_eol, widen(cap_rgb)});
      if (cap_sof) m_frames = m_frames + 16'd1;
      m_stream = 1'b1;
    end
    if (dropf) m_stream = 1'b0;
    if (clear_status) begin
      m_ovf = 1'b0;
      m_drops = '0;
    end else begin
      if (dropf) m_ovf = 1'b1;
      if ((disc || dropf) && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    end
    cap_v   = video_on;
    cap_rgb = rgb_in;
    cap_sof = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    cap_eol = (pixel_x == 10'(H - 1));
  endtask

  // One clock: check outputs against the model, drive next inputs, advance model and raster.
  task automatic step();
    logic [25:0] f;
    @(negedge clk);
    check_val("tvalid", 32'(tvalid), 32'(m_q.size() != 0));
    check_val("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check_val("frame_count", 32'(frame_count), 32'(m_frames));
    check_val("drop_count", 32'(drop_count), 32'(m_drops));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      f = m_q[0];
      check_val("tdata", 32'(tdata), 32'(f[23:0]));
      check_val("tlast", 32'(tlast), 32'(f[24]));
      check_val("tuser", 32'(tuser), 32'(f[25]));
    end
    if (probe > 0) begin
      probe--;
      if (probe == 0) check_val("expand_a5c", 32'(tdata), 32'h00AA55CC);
    end
    reset        = reset_drv;
    video_on     = (hx < H) && (vy < V);
    pixel_x      = 10'(hx);
    pixel_y      = 10'(vy);
    rgb_in       = (hx == 3 && vy == 1) ? 12'hA5C : 12'($urandom_range(0, 4095));
    if (hx == 3 && vy == 1 && probe_arm) probe = 2;
    tready       = tready_drv;
    clear_status = clear_drv;
    if (tvalid && tready) begin
      $display("beat %0d tdata %h tuser %0b tlast %0b", bc, tdata, tuser, tlast);
      bc++;
      if (tuser) uc++;
      if (tlast) lc++;
    end
    if (!reset) model_reset();
    else        model_edge();
    hx++;
    if (hx == HT) begin
      hx = 0;
      vy++;
      if (vy == VT) vy = 0;
    end
  endtask

  task automatic run_to(input int x, input int y);
    int guard = 0;
    while (!(hx == x && vy == y)) begin
      step();
      guard++;
      if (guard > 2 * HT * VT) begin
        check_val("run_to_timeout", 32'(guard), 32'(0));
        break;
      end
    end
  endtask

  task automatic clear_beats();
    bc = 0; uc = 0; lc = 0;
  endtask

  task automatic check_frame(input string tag, input int frames);
    check_val({tag, "_beats"}, 32'(bc), 32'(H * V));
    check_val({tag, "_tuser"}, 32'(uc), 32'(1));
    check_val({tag, "_tlast"}, 32'(lc), 32'(V));
    check_val({tag, "_frames"}, 32'(frame_count), 32'(frames));
  endtask

  initial begin
    reset = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0; rgb_in = '0;
    tready = 1'b0; clear_status = 1'b0;
    reset_drv = 1'b0; tready_drv = 1'b1; clear_drv = 1'b0;
    model_reset();
    #1;
    check_val("rst_tvalid", 32'(tvalid), 32'(0));
    check_val("rst_tdata", 32'(tdata), 32'(0));
    check_val("rst_level", 32'(fifo_level), 32'(0));
    check_val("rst_counts", 32'({frame_count, drop_count}), 32'(0));

    // Release at pixel (5,0): frame 0 is discarded, frame 1 streams completely.
    repeat (5) step();
    reset_drv = 1'b1;
    run_to(0, 0);
    check_val("f0_beats", 32'(bc), 32'(0));
    check_val("f0_drops", 32'(drop_count), 32'((H - 5) + H * (V - 1)));
    clear_beats();
    probe_arm = 1'b1;
    repeat (HT * VT) step();
    probe_arm = 1'b0;
    check_frame("f1", 1);
    check_val("f1_drops", 32'(drop_count), 32'((H - 5) + H * (V - 1)));

    // Frame 2: 10-cycle stall from an empty FIFO.
    run_to(1, 1);
    tready_drv = 1'b0;
    repeat (10) step();
    tready_drv = 1'b1;
    @(posedge clk); #1;
    check_val("bp_level", 32'(fifo_level), 32'(10));
    check_val("bp_overflow", 32'(overflow), 32'(0));

    // Frame 3: fill to 16, then push and pop in the same cycle.
    run_to(0, 0);
    run_to(0, 1);
    tready_drv = 1'b0;
    repeat (21) step();
    @(posedge clk); #1;
    check_val("full_level", 32'(fifo_level), 32'(DEPTH));
    tready_drv = 1'b1;
    step();
    @(posedge clk); #1;
    check_val("fullpop_level", 32'(fifo_level), 32'(DEPTH));
    check_val("fullpop_overflow", 32'(overflow), 32'(0));
    check_val("fullpop_drops", 32'(drop_count), 32'((H - 5) + H * (V - 1)));

    // Frame 4: overflow, resync, clear during a discard.
    run_to(0, 0);
    run_to(0, 1);
    tready_drv = 1'b0;
    repeat (22) step();
    @(posedge clk); #1;
    check_val("ovf_set", 32'(overflow), 32'(1));
    check_val("ovf_drops", 32'(drop_count), 32'((H - 5) + H * (V - 1) + 1));
    repeat (8) step();
    tready_drv = 1'b1;
    clear_drv = 1'b1;
    step();
    clear_drv = 1'b0;
    @(posedge clk); #1;
    check_val("clr_overflow", 32'(overflow), 32'(0));
    check_val("clr_drops", 32'(drop_count), 32'(0));
    run_to(0, 0);
    check_val("resync_drops", 32'(drop_count), 32'((H - 10) + H));

    // Frame 5: complete frame after resync.
    clear_beats();
    repeat (HT * VT) step();
    check_frame("f5", 5);

    // Frame 6: asynchronous reset mid-line, output resumes at frame 7.
    run_to(5, 2);
    @(posedge clk); #2;
    check_val("pre_rst_tvalid", 32'(tvalid), 32'(1));
    reset = 1'b0;
    reset_drv = 1'b0;
    #1;
    check_val("arst_tvalid", 32'(tvalid), 32'(0));
    check_val("arst_tdata", 32'(tdata), 32'(0));
    check_val("arst_flags", 32'({tuser, tlast, overflow}), 32'(0));
    check_val("arst_level", 32'(fifo_level), 32'(0));
    check_val("arst_counts", 32'({frame_count, drop_count}), 32'(0));
    model_reset();
    step();
    reset_drv = 1'b1;
    run_to(0, 0);
    clear_beats();
    repeat (HT * VT) step();
    check_frame("f7", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
